// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: IF stage and IF/ID pipeline register of the 5-stage MIPS core.
//
// Holds the fetch PC (PCF), drives the instruction-memory address, computes
// the next PC from the decode controller's PCControl select, and registers
// the fetched word into ID together with its PC+4 / PC+8 link values.
//
// Build option:
//   DELAY_SLOT_EN  defined   -> MIPS branch delay slot: the word fetched
//                               alongside a redirect enters ID normally.
//                  undefined -> that word is squashed into a bubble
//                               (NOP_INSTR, ValidD=0, AdelD=0).
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  PCControl,
    input  logic [31:0] RegRsD,
    input  logic [31:0] IRdata,
    output logic [31:0] IAddr,
    output logic [31:0] InstrD,
    output logic [31:0] PC4D,
    output logic [31:0] PC8D,
    output logic        ValidD,
    output logic        AdelD
);

    // Next-PC sources, in PCControl encoding order.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_REG    = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

    logic [31:0] pcf;
    logic [31:0] npc;
    logic [31:0] branch_off;
    logic        misaligned;
    logic        squash;
    logic        first_fetch;
    logic        valid_q;

    assign IAddr      = pcf;
    assign misaligned = (pcf[1:0] != 2'b00);

    // Sign-extended, word-scaled beq displacement taken from the ID instruction.
    assign branch_off = {{14{InstrD[15]}}, InstrD[15:0], 2'b00};

`ifdef DELAY_SLOT_EN
    // The word fetched alongside a redirect is the delay slot and is kept.
    assign squash = 1'b0;
`else
    // Without a delay slot the word fetched alongside a redirect is wrong-path.
    assign squash = (PCControl != PC_SEQ);
`endif

    // A bubble is invisible to ID until the first unstalled edge after reset.
    assign ValidD = valid_q & ~first_fetch;

    // Next-PC mux driven by the decode controller's select.
    always_comb begin
        // NOTE: default assignment first so every path drives npc and no latch is inferred.
        npc = pcf + 32'd4;
        case (pc_sel_e'(PCControl))
            PC_SEQ:    npc = pcf + 32'd4;
            PC_BRANCH: npc = PC4D + branch_off;
            PC_REG:    npc = RegRsD;
            PC_JUMP:   npc = {PC4D[31:28], InstrD[25:0], 2'b00};
        endcase
    end

    // Fetch PC register; a misaligned target is still loaded as-is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcf <= RESET_PC;
        end else if (!Stall) begin
            // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
            pcf <= npc;
        end
    end

    // First-fetch flag: set by reset, cleared by the first unstalled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_fetch <= 1'b1;
        end else if (!Stall) begin
            first_fetch <= 1'b0;
        end
    end

    // IF/ID pipeline register: load fetched word, bubble, or hold on stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD  <= NOP_INSTR;
            PC4D    <= RESET_PC;
            PC8D    <= RESET_PC + 32'd4;
            valid_q <= 1'b0;
            AdelD   <= 1'b0;
        end else if (!Stall) begin
            PC4D <= pcf + 32'd4;
            PC8D <= pcf + 32'd8;
            if (squash) begin
                InstrD  <= NOP_INSTR;
                valid_q <= 1'b0;
                AdelD   <= 1'b0;
            end else begin
                // A misaligned fetch discards the memory word and flags AdelD for ID.
                InstrD  <= misaligned ? NOP_INSTR : IRdata;
                valid_q <= 1'b1;
                AdelD   <= misaligned;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage: directed table-driven bench for fetch_stage, plus hand-written
// sequences for asynchronous reset and reset held across a stall.
// Expectations follow the build: DELAY_SLOT_EN selects the delay-slot results.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic [1:0]  PCControl;
    logic [31:0] RegRsD;
    logic [31:0] IRdata;
    logic [31:0] IAddr;
    logic [31:0] InstrD;
    logic [31:0] PC4D;
    logic [31:0] PC8D;
    logic        ValidD;
    logic        AdelD;

    int n_applied = 0;
    int n_miss    = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_3000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .PCControl (PCControl),
        .RegRsD    (RegRsD),
        .IRdata    (IRdata),
        .IAddr     (IAddr),
        .InstrD    (InstrD),
        .PC4D      (PC4D),
        .PC8D      (PC8D),
        .ValidD    (ValidD),
        .AdelD     (AdelD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  ctl;
        logic [31:0] rs;
        logic [31:0] ir;
        logic [31:0] iaddr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic        valid;
        logic        adel;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic stall, input logic [1:0] ctl,
                                input logic [31:0] rs, input logic [31:0] ir,
                                input logic [31:0] iaddr, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic [31:0] pc8,
                                input logic valid, input logic adel);
        vec_t v;
        v.stall = stall; v.ctl = ctl; v.rs = rs; v.ir = ir;
        v.iaddr = iaddr; v.instr = instr; v.pc4 = pc4; v.pc8 = pc8;
        v.valid = valid; v.adel = adel;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " IAddr"},  IAddr,         v.iaddr);
        check({tag, " InstrD"}, InstrD,        v.instr);
        check({tag, " PC4D"},   PC4D,          v.pc4);
        check({tag, " PC8D"},   PC8D,          v.pc8);
        check({tag, " ValidD"}, 32'(ValidD),   32'(v.valid));
        check({tag, " AdelD"},  32'(AdelD),    32'(v.adel));
    endtask

    initial begin
        //                 stall ctl rs            ir              -> IAddr         InstrD                      PC4D          PC8D          V         A
        // sequential fetch from reset
        vecs[0]  = mk(0, 2'd0, 32'h0,         32'h1111_3000, 32'h0000_3004, 32'h1111_3000,               32'h0000_3004, 32'h0000_3008, 1,        0);
        vecs[1]  = mk(0, 2'd0, 32'h0,         32'h1000_FFFF, 32'h0000_3008, 32'h1000_FFFF,               32'h0000_3008, 32'h0000_300C, 1,        0);
        // beq in ID (imm FFFF, PC4D 3008) -> target 3004
        vecs[2]  = mk(0, 2'd1, 32'h0,         32'h3333_3008, 32'h0000_3004, DS ? 32'h3333_3008 : NOP,    32'h0000_300C, 32'h0000_3010, DS,       0);
        vecs[3]  = mk(0, 2'd0, 32'h0,         32'h5555_3004, 32'h0000_3008, 32'h5555_3004,               32'h0000_3008, 32'h0000_300C, 1,        0);
        vecs[4]  = mk(0, 2'd0, 32'h0,         32'h6666_3008, 32'h0000_300C, 32'h6666_3008,               32'h0000_300C, 32'h0000_3010, 1,        0);
        vecs[5]  = mk(0, 2'd0, 32'h0,         32'h0800_0C40, 32'h0000_3010, 32'h0800_0C40,               32'h0000_3010, 32'h0000_3014, 1,        0);
        // j in ID (index 0C40, PC4D 3010) -> 3100
        vecs[6]  = mk(0, 2'd3, 32'h0,         32'h7777_3010, 32'h0000_3100, DS ? 32'h7777_3010 : NOP,    32'h0000_3014, 32'h0000_3018, DS,       0);
        vecs[7]  = mk(0, 2'd0, 32'h0,         32'h8888_3100, 32'h0000_3104, 32'h8888_3100,               32'h0000_3104, 32'h0000_3108, 1,        0);
        // jr to misaligned 3202, then misaligned sequential fetches
        vecs[8]  = mk(0, 2'd2, 32'h0000_3202, 32'h9999_3104, 32'h0000_3202, DS ? 32'h9999_3104 : NOP,    32'h0000_3108, 32'h0000_310C, DS,       0);
        vecs[9]  = mk(0, 2'd0, 32'h0,         32'hDEAD_BEEF, 32'h0000_3206, NOP,                         32'h0000_3206, 32'h0000_320A, 1,        1);
        vecs[10] = mk(0, 2'd0, 32'h0,         32'hCAFE_F00D, 32'h0000_320A, NOP,                         32'h0000_320A, 32'h0000_320E, 1,        1);
        // jr to 3400 from a misaligned fetch slot
        vecs[11] = mk(0, 2'd2, 32'h0000_3400, 32'h4242_4242, 32'h0000_3400, NOP,                         32'h0000_320E, 32'h0000_3212, DS,       DS);
        vecs[12] = mk(0, 2'd0, 32'h0,         32'h0800_0D00, 32'h0000_3404, 32'h0800_0D00,               32'h0000_3404, 32'h0000_3408, 1,        0);
        // stall for 3 cycles with a jump select present: everything holds
        vecs[13] = mk(1, 2'd3, 32'h0,         32'h1234_5678, 32'h0000_3404, 32'h0800_0D00,               32'h0000_3404, 32'h0000_3408, 1,        0);
        vecs[14] = mk(1, 2'd3, 32'h0,         32'h1234_5678, 32'h0000_3404, 32'h0800_0D00,               32'h0000_3404, 32'h0000_3408, 1,        0);
        vecs[15] = mk(1, 2'd3, 32'h0,         32'h1234_5678, 32'h0000_3404, 32'h0800_0D00,               32'h0000_3404, 32'h0000_3408, 1,        0);
        // stall drops: the jump (index 0D00) applies now -> 3400
        vecs[16] = mk(0, 2'd3, 32'h0,         32'hABCD_3404, 32'h0000_3400, DS ? 32'hABCD_3404 : NOP,    32'h0000_3408, 32'h0000_340C, DS,       0);
        // jr to FFFFFFFC, then sequential wrap to 0
        vecs[17] = mk(0, 2'd2, 32'hFFFF_FFFC, 32'h1111_0000, 32'hFFFF_FFFC, DS ? 32'h1111_0000 : NOP,    32'h0000_3404, 32'h0000_3408, DS,       0);
        vecs[18] = mk(0, 2'd0, 32'h0,         32'hF00D_FFFC, 32'h0000_0000, 32'hF00D_FFFC,               32'h0000_0000, 32'h0000_0004, 1,        0);
        // jr back to 3400 for the asynchronous reset sequence
        vecs[19] = mk(0, 2'd2, 32'h0000_3400, 32'h0000_0005, 32'h0000_3400, DS ? 32'h0000_0005 : NOP,    32'h0000_0004, 32'h0000_0008, DS,       0);

        reset     = 1'b1;
        Stall     = 1'b0;
        PCControl = 2'd0;
        RegRsD    = 32'h0;
        IRdata    = 32'h0;

        // Reset state before any clock edge.
        #2;
        check_all("reset", mk(0, 2'd0, 32'h0, 32'h0, 32'h0000_3000, NOP, 32'h0000_3000, 32'h0000_3004, 0, 0));

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            Stall     = vecs[i].stall;
            PCControl = vecs[i].ctl;
            RegRsD    = vecs[i].rs;
            IRdata    = vecs[i].ir;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Asynchronous reset between edges while PCF=3400: no clock edge needed.
        PCControl = 2'd0;
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", mk(0, 2'd0, 32'h0, 32'h0, 32'h0000_3000, NOP, 32'h0000_3000, 32'h0000_3004, 0, 0));

        // Reset held across a stalled, redirecting edge: reset wins.
        Stall     = 1'b1;
        PCControl = 2'd3;
        @(posedge clk);
        #1;
        check("rst_stall IAddr", IAddr, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_stall IAddr",  IAddr,        32'h0000_3000);
        check("post_rst_stall ValidD", 32'(ValidD),  32'd0);
        @(negedge clk);

        // First unstalled edge after reset fetches from RESET_PC.
        Stall     = 1'b0;
        PCControl = 2'd0;
        IRdata    = 32'hFEED_3000;
        @(posedge clk);
        #1;
        check_all("first_fetch", mk(0, 2'd0, 32'h0, 32'h0, 32'h0000_3004, 32'hFEED_3000, 32'h0000_3004, 32'h0000_3008, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
